// File: rtl/pcie_link_err_monitor.sv
// PCIe link error monitor: qualifies PHY/PCS error strobes over a tumbling
// window while the link is in L0 and raises a one-cycle error_detected pulse
// toward the LTSSM. Repeated reports with no clean window in between escalate
// to a one-cycle training_req pulse instead.
module pcie_link_err_monitor #(
  parameter int WIN_CYCLES    = 1024,
  parameter int ERR_THRESH    = 4,
  parameter int RETRAIN_LIMIT = 3,
  parameter int HOLDOFF       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up,
  input  logic        crc_err,
  input  logic        deskew_err,
  input  logic        lock_lost,
  input  logic        clr_stats,
  output logic        error_detected,
  output logic        training_req,
  output logic [3:0]  recov_count,
  output logic [15:0] err_total,
  output logic [1:0]  mon_state
);

  localparam int WCW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    WAIT_UP   = 2'd0,
    MONITOR   = 2'd1,
    REPORT    = 2'd2,
    WAIT_DOWN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [WCW-1:0]  win_cnt_q, win_cnt_d;
  logic [7:0]      win_errs_q, win_errs_d;
  logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]      recov_q, recov_d;
  logic [15:0]     err_total_q, err_total_d;
  logic            err_det_q, err_det_d;
  logic            train_q, train_d;

  logic [1:0]  inc;
  logic [8:0]  err_sum;
  logic [16:0] total_sum;
  logic        wrap, clean, trigger;
  logic [3:0]  recov_base;
  logic [4:0]  recov_nxt;

  // Next-state and datapath: window bookkeeping, trigger/escalation, stats
  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    win_errs_d  = win_errs_q;
    hold_cnt_d  = hold_cnt_q;
    recov_d     = recov_q;
    err_total_d = err_total_q;
    err_det_d   = 1'b0;
    train_d     = 1'b0;

    // Simultaneous strobes count as two errors.
    inc        = {1'b0, crc_err} + {1'b0, deskew_err};
    // 9-bit sum: win_errs tops out below ERR_THRESH, so this never wraps.
    err_sum    = {1'b0, win_errs_q} + {7'b0, inc};
    total_sum  = {1'b0, err_total_q} + {15'b0, inc};
    wrap       = (win_cnt_q == WCW'(WIN_CYCLES - 1));
    // A window that closes with no errors, and none arriving on the wrap
    // cycle, means the link has recovered: forget earlier reports.
    clean      = wrap && (win_errs_q == 8'd0) && (inc == 2'd0);
    recov_base = clean ? 4'd0 : recov_q;
    recov_nxt  = {1'b0, recov_base} + 5'd1;
    trigger    = (err_sum >= 9'(ERR_THRESH)) || lock_lost;

    unique case (state_q)
      WAIT_UP: begin
        win_cnt_d  = '0;
        win_errs_d = '0;
        if (link_up) state_d = MONITOR;
      end
      MONITOR: begin
        err_total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
        recov_d     = recov_base;
        if (trigger) begin
          // Pulses are issued on entry so they are visible during REPORT.
          state_d    = REPORT;
          win_cnt_d  = '0;
          win_errs_d = '0;
          if (recov_nxt >= 5'(RETRAIN_LIMIT)) begin
            train_d = 1'b1;
            recov_d = 4'd0;
          end else begin
            err_det_d = 1'b1;
            recov_d   = recov_nxt[3:0];
          end
        end else if (!link_up) begin
          state_d    = WAIT_UP;
          win_cnt_d  = '0;
          win_errs_d = '0;
        end else begin
          win_cnt_d  = wrap ? '0 : win_cnt_q + 1'b1;
          win_errs_d = wrap ? {6'b0, inc} : err_sum[7:0];
        end
      end
      REPORT: begin
        state_d    = WAIT_DOWN;
        hold_cnt_d = '0;
        win_cnt_d  = '0;
        win_errs_d = '0;
      end
      WAIT_DOWN: begin
        if (!link_up) begin
          state_d = WAIT_UP;
        end else if (hold_cnt_q == HCW'(HOLDOFF - 1)) begin
          state_d    = MONITOR;
          win_cnt_d  = '0;
          win_errs_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_UP;
    endcase

    // Clearing statistics takes priority over counting in the same cycle.
    if (clr_stats) err_total_d = 16'd0;
  end

  // State and output registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_UP;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      hold_cnt_q  <= '0;
      recov_q     <= '0;
      err_total_q <= '0;
      err_det_q   <= 1'b0;
      train_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      win_errs_q  <= win_errs_d;
      hold_cnt_q  <= hold_cnt_d;
      recov_q     <= recov_d;
      err_total_q <= err_total_d;
      err_det_q   <= err_det_d;
      train_q     <= train_d;
    end
  end

  assign error_detected = err_det_q;
  assign training_req   = train_q;
  assign recov_count    = recov_q;
  assign err_total      = err_total_q;
  assign mon_state      = state_q;

endmodule

// File: tb/tb_pcie_link_err_monitor.sv
// Bench for pcie_link_err_monitor: directed scenarios plus random traffic,
// compared against a cycle-level reference model with a pulse scoreboard.
module tb_pcie_link_err_monitor;

  localparam int WIN = 1024;
  localparam int TH  = 4;
  localparam int RL  = 3;
  localparam int HO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b0, crc_err = 1'b0, deskew_err = 1'b0;
  logic        lock_lost = 1'b0, clr_stats = 1'b0;
  logic        error_detected, training_req;
  logic [3:0]  recov_count;
  logic [15:0] err_total;
  logic [1:0]  mon_state;

  pcie_link_err_monitor #(
    .WIN_CYCLES(WIN), .ERR_THRESH(TH), .RETRAIN_LIMIT(RL), .HOLDOFF(HO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .link_up(link_up), .crc_err(crc_err),
    .deskew_err(deskew_err), .lock_lost(lock_lost), .clr_stats(clr_stats),
    .error_detected(error_detected), .training_req(training_req),
    .recov_count(recov_count), .err_total(err_total), .mon_state(mon_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int c;
    bit tr;
    int rc;
    int et;
  } exp_t;
  exp_t q[$];

  // Reference model: phase 0 link down, 1 watching, 2 reporting, 3 cooling off.
  // m_t counts cycles spent watching; window position is m_t mod WIN.
  int m_st, m_t, m_we, m_h, m_rc, m_et;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_t = 0; m_we = 0; m_h = 0; m_rc = 0; m_et = 0;
    q.delete();
  endtask

  task automatic model_step(input bit l, input bit c, input bit d,
                            input bit lk, input bit cl);
    int inc, base, n;
    bit last, clean, trig;
    exp_t e;
    inc  = int'(c) + int'(d);
    trig = 1'b0;
    e    = '{c: 0, tr: 1'b0, rc: 0, et: 0};
    case (m_st)
      0: if (l) begin m_st = 1; m_t = 0; m_we = 0; end
      1: begin
        last  = ((m_t % WIN) == WIN - 1);
        clean = last && (m_we == 0) && (inc == 0);
        base  = clean ? 0 : m_rc;
        m_et  = (m_et + inc > 65535) ? 65535 : m_et + inc;
        trig  = (m_we + inc >= TH) || lk;
        if (trig) begin
          n    = base + 1;
          e.c  = cyc + 1;
          e.tr = (n >= RL);
          m_rc = e.tr ? 0 : n;
          e.rc = m_rc;
          m_st = 2;
        end else if (!l) begin
          m_rc = base;
          m_st = 0;
        end else begin
          m_rc = base;
          m_we = last ? inc : m_we + inc;
          m_t++;
        end
      end
      2: begin m_st = 3; m_h = 0; end
      default: begin
        if (!l) m_st = 0;
        else if (m_h == HO - 1) begin m_st = 1; m_t = 0; m_we = 0; end
        else m_h++;
      end
    endcase
    if (cl) m_et = 0;
    if (trig) begin
      e.et = m_et;
      q.push_back(e);
    end
  endtask

  // One clock of stimulus: applied on the falling edge, sampled on the next rise.
  task automatic drive(input bit l, input bit c, input bit d,
                       input bit lk, input bit cl);
    @(negedge clk);
    link_up = l; crc_err = c; deskew_err = d; lock_lost = lk; clr_stats = cl;
    model_step(l, c, d, lk, cl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    link_up = 1'b0; crc_err = 1'b0; deskew_err = 1'b0;
    lock_lost = 1'b0; clr_stats = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle status against the model, pulses against the scoreboard.
  exp_t e_mon;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("state", int'(mon_state), m_st);
      chk("recov", int'(recov_count), m_rc);
      chk("err_total", int'(err_total), m_et);
      if (error_detected || training_req) begin
        chk("pulse_exclusive", int'(error_detected & training_req), 0);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got ed=%0d tr=%0d expected none (cycle %0d)",
                   error_detected, training_req, cyc);
        end else begin
          e_mon = q.pop_front();
          chk("pulse_cycle", cyc, e_mon.c);
          chk("pulse_kind_tr", int'(training_req), int'(e_mon.tr));
          chk("pulse_recov", int'(recov_count), e_mon.rc);
          chk("pulse_err_total", int'(err_total), e_mon.et);
        end
      end else if (q.size() > 0 && q[0].c <= cyc) begin
        checks++; errors++;
        $display("FAIL missed_pulse: got none expected pulse at cycle %0d (cycle %0d)",
                 q[0].c, cyc);
        void'(q.pop_front());
      end
    end
  end

  int exp_rc[3] = '{1, 2, 0};
  int down, rate;
  bit l, c, d;

  initial begin
    model_reset();
    do_reset();
    #1;
    chk("rst_state", int'(mon_state), 0);
    chk("rst_ed", int'(error_detected), 0);
    chk("rst_tr", int'(training_req), 0);
    chk("rst_recov", int'(recov_count), 0);
    chk("rst_total", int'(err_total), 0);

    // Below-threshold errors in one window, then a long quiet stretch.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(99);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    idle(2048);
    #6;
    chk("t1_total", int'(err_total), 3);
    chk("t1_recov", int'(recov_count), 0);

    // Four spaced CRC errors: report exactly one cycle after the fourth.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) drive(1'b1, (i % 10) == 0, 1'b0, 1'b0, 1'b0);
    #6;
    chk("t2_ed", int'(error_detected), 1);
    chk("t2_recov", int'(recov_count), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #6;
    chk("t2_ed_drop", int'(error_detected), 0);
    chk("t2_state", int'(mon_state), 3);

    // Double strobes on two consecutive cycles.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #6;
    chk("t3_ed", int'(error_detected), 1);
    chk("t3_total", int'(err_total), 4);

    // Lock loss with no errors, then holdoff back to monitoring.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #6;
    chk("t4_ed", int'(error_detected), 1);
    idle(16);
    #6;
    chk("t4_still_down", int'(mon_state), 3);
    idle(1);
    #6;
    chk("t4_back_monitor", int'(mon_state), 1);

    // Escalation after three reports with link bounces and no clean window.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      #6;
      chk("t5_ed", int'(error_detected), (k < 2) ? 1 : 0);
      chk("t5_tr", int'(training_req), (k == 2) ? 1 : 0);
      chk("t5_recov", int'(recov_count), exp_rc[k]);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // A clean window between reports resets the escalation count.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      idle(4);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    #6;
    chk("t6_recov_pre", int'(recov_count), 2);
    idle(1100);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #6;
    chk("t6_ed", int'(error_detected), 1);
    chk("t6_tr", int'(training_req), 0);
    chk("t6_recov", int'(recov_count), 1);

    // Asynchronous reset while the report pulse is high.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #7;
    chk("t7_ed_before", int'(error_detected), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_ed_rst", int'(error_detected), 0);
    chk("t7_tr_rst", int'(training_req), 0);
    chk("t7_state_rst", int'(mon_state), 0);
    do_reset();

    // Random traffic with varying error rates, link drops, lock loss, clears.
    do_reset();
    down = 0;
    rate = 0;
    for (int i = 0; i < 30000; i++) begin
      if (i % 2000 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 0;
          1: rate = 1000;
          2: rate = 200;
          default: rate = 40;
        endcase
      end
      if (down > 0) down--;
      else if ($urandom_range(0, 1499) == 0) down = $urandom_range(1, 20);
      l = (down == 0);
      c = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
      d = (rate != 0) && ($urandom_range(0, rate - 1) == 0);
      drive(l, c, d, $urandom_range(0, 4999) == 0, $urandom_range(0, 2999) == 0);
    end
    idle(4);
    #6;
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_link_err_monitor.md
Name: pcie_link_err_monitor

Overview:
Upstream error-qualification stage for the PCIe LTSSM. It watches PHY/PCS error strobes while the link is up and counts them over a tumbling time window. When the error budget is exceeded it issues a one-cycle error_detected pulse toward the LTSSM. Repeated triggers without an intervening clean window escalate to a one-cycle training_req pulse instead.

Parameters:
WIN_CYCLES, 1024, tumbling window length in clk cycles (>=2).
ERR_THRESH, 4, error count within one window that triggers a report (1..255).
RETRAIN_LIMIT, 3, trigger count that escalates to training_req (1..15).
HOLDOFF, 16, max cycles to wait for link_up to fall after a report.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
link_up  in  1  LTSSM link_up (1 only in L0)
crc_err  in  1  single-cycle CRC error strobe
deskew_err  in  1  single-cycle lane deskew/disparity error strobe
lock_lost  in  1  PHY lock loss; any-cycle assertion forces an immediate report
clr_stats  in  1  synchronous clear of err_total
error_detected  out  1  one-cycle pulse to LTSSM
training_req  out  1  one-cycle pulse to LTSSM
recov_count  out  4  triggers since last clean window
err_total  out  16  saturating total counted errors
mon_state  out  2  FSM state code, for coverage

Behaviour:
- Reset is asynchronous and active-low. Clock is clk. On reset, all outputs and counters are 0 and the FSM is in WAIT_UP.
- All outputs are registered.
- FSM encoding: WAIT_UP=0, MONITOR=1, REPORT=2, WAIT_DOWN=3.
- WAIT_UP:
  - Ignores all error inputs; win_cnt=0, win_errs=0.
  - When link_up=1 is sampled, goes to MONITOR next cycle.
- MONITOR:
  - Per-cycle increment inc = crc_err + deskew_err (0..2). Simultaneous strobes count 2.
  - win_cnt counts 0..WIN_CYCLES-1 and wraps.
  - On the wrap cycle, win_errs loads inc (the error counts into the new window).
  - If the closing window had win_errs=0 and inc=0, recov_count clears to 0.
  - err_total += inc, saturating at 0xFFFF. clr_stats wins over the increment in the same cycle.
  - Trigger condition: (win_errs + inc >= ERR_THRESH) or lock_lost. The comparison is 9-bit, so win_errs never overflows.
  - On trigger, go to REPORT.
  - If link_up=0 is sampled without a trigger, go to WAIT_UP. recov_count is unchanged.
  - Trigger and link_up=0 in the same cycle: trigger wins.
- REPORT (exactly one cycle):
  - recov_count_next = recov_count + 1.
  - If recov_count_next >= RETRAIN_LIMIT: training_req=1 this cycle and recov_count clears to 0.
  - Otherwise: error_detected=1 this cycle and recov_count = recov_count_next.
  - Never both pulses at once.
  - win_errs and win_cnt clear. Next state is WAIT_DOWN.
- Latency: the error sampled at edge N produces the pulse output high during cycle N+1.
- WAIT_DOWN:
  - Ignores errors.
  - If link_up=0 is sampled, go to WAIT_UP.
  - Else, after HOLDOFF cycles in this state (counter 0..HOLDOFF-1), return to MONITOR with the window cleared.
- err_total counts only in MONITOR.
- Reset mid-REPORT forces outputs to 0 immediately (async).

Test Plan:
- Default params, link_up=1, 3 crc_err pulses within 1024 cycles, then quiet for 2048 cycles -> no pulses; err_total=3; recov_count stays 0.
- 4 crc_err pulses at cycles 10, 20, 30, 40 -> error_detected high for exactly 1 cycle at cycle 41; recov_count=1; mon_state=3 at cycle 42.
- crc_err and deskew_err together at cycles 10 and 11 -> error_detected at cycle 12; err_total=4.
- lock_lost for 1 cycle with zero prior errors -> error_detected the next cycle. Then hold link_up=1 -> mon_state returns to 1 after 16 cycles in WAIT_DOWN.
- Three consecutive triggers, each followed by link_up 1->0->1, with no clean window -> pulses are error_detected, error_detected, then training_req; recov_count reads 1, 2, 0.
- Trigger followed by 1024+ clean cycles, then another trigger -> error_detected (not training_req), recov_count=1. Separately, assert rst_n=0 during REPORT -> error_detected and training_req drop to 0 immediately; mon_state=0.
